// File: rtl/synth_gpio_ctrl.sv
// synth_gpio_ctrl: Avalon-MM GPIO block with per-bit direction, synchronised
// inputs with edge capture and masked interrupt, set/clear output access,
// and a timed pulse generator that forces selected output bits high.
module synth_gpio_ctrl #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               EDGE_TYPE    = 0,
  parameter int               PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_DIR    = 3'd1,
    ADDR_MASK   = 3'd2,
    ADDR_EDGE   = 3'd3,
    ADDR_OUTSET = 3'd4,
    ADDR_OUTCLR = 3'd5,
    ADDR_PULSE  = 3'd6
  } addr_e;

  typedef enum logic {IDLE, ACTIVE} pulse_state_e;

  localparam logic [19:0] PULSE_LOAD = 20'(PULSE_CYCLES);

  logic [WIDTH-1:0] data_reg, dir_reg, mask_reg, edge_reg, pulse_mask;
  logic [WIDTH-1:0] sync_meta, in_sync, in_prev, edge_det, wmask;
  logic [19:0]      counter;
  pulse_state_e     state;
  logic             irq_q, wr, pulse_wr, busy;
  logic             unused_wdata_bits;

  assign wr       = chipselect & ~write_n;
  assign wmask    = writedata[WIDTH-1:0];
  assign pulse_wr = wr && (address == ADDR_PULSE) && (wmask != '0);
  assign busy     = (state == ACTIVE);

  // Write-data bits above WIDTH have no storage behind them.
  assign unused_wdata_bits = ^writedata;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      in_sync   <= '0;
      in_prev   <= '0;
    end else begin
      sync_meta <= in_port;
      in_sync   <= sync_meta;
      in_prev   <= in_sync;
    end
  end

  // Per-bit edge detection selected at elaboration time.
  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_sync & ~in_prev;
      1:       edge_det = ~in_sync & in_prev;
      default: edge_det = in_sync ^ in_prev;
    endcase
  end

  // Sticky edge capture; a fresh edge outranks a same-cycle W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_reg <= '0;
    end else if (wr && address == ADDR_EDGE) begin
      edge_reg <= (edge_reg & ~wmask) | edge_det;
    end else begin
      edge_reg <= edge_reg | edge_det;
    end
  end

  // Registered level interrupt from captured, unmasked edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |(edge_reg & mask_reg);
  end

  // Output data, direction and interrupt-mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
      dir_reg  <= '0;
      mask_reg <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_reg <= wmask;
        ADDR_DIR:    dir_reg  <= wmask;
        ADDR_MASK:   mask_reg <= wmask;
        ADDR_OUTSET: data_reg <= data_reg | wmask;
        ADDR_OUTCLR: data_reg <= data_reg & ~wmask;
        default:     ;
      endcase
    end
  end

  // Pulse generator: a write (re)starts a PULSE_CYCLES-long window and ORs in
  // its mask; the window closes on the cycle the counter reaches 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      pulse_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_wr) begin
            state      <= ACTIVE;
            counter    <= PULSE_LOAD;
            pulse_mask <= pulse_mask | wmask;
          end
        end
        ACTIVE: begin
          if (pulse_wr) begin
            counter    <= PULSE_LOAD;
            pulse_mask <= pulse_mask | wmask;
          end else if (counter == 20'd1) begin
            state      <= IDLE;
            counter    <= '0;
            pulse_mask <= '0;
          end else begin
            counter    <= counter - 20'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-wait-state read mux; unused and write-only addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata = 32'(in_sync);
      ADDR_DIR:   readdata = 32'(dir_reg);
      ADDR_MASK:  readdata = 32'(mask_reg);
      ADDR_EDGE:  readdata = 32'(edge_reg);
      ADDR_PULSE: readdata = {31'b0, busy};
      default:    readdata = '0;
    endcase
  end

  assign out_port = data_reg | pulse_mask;
  assign out_en   = dir_reg;
  assign irq      = irq_q;

endmodule

// File: tb/tb_synth_gpio_ctrl.sv
// Bench for synth_gpio_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model. A second instance captures
// any edge so both detection paths are exercised from the same stimulus.
module tb_synth_gpio_ctrl;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;
  localparam int         P  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0]  readdata_r, readdata_a;
  logic [W-1:0] out_port_r, out_port_a, out_en_r, out_en_a;
  logic         irq_r, irq_a;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] m_data, m_dir, m_mask, m_edge, m_edge_any, m_pmask;
  logic       m_irq, m_irq_any;
  int         m_left;
  logic [7:0] h1, h2, h3;   // pin samples: 1, 2, 3 clock edges ago

  always #5 clk = ~clk;

  synth_gpio_ctrl #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(0), .PULSE_CYCLES(P)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_r),
    .in_port(in_port), .out_port(out_port_r), .out_en(out_en_r), .irq(irq_r));

  synth_gpio_ctrl #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(2), .PULSE_CYCLES(P)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_port), .out_port(out_port_a), .out_en(out_en_a), .irq(irq_a));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_data = RV; m_dir = '0; m_mask = '0; m_edge = '0; m_edge_any = '0;
    m_pmask = '0; m_irq = 1'b0; m_irq_any = 1'b0; m_left = 0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a, input bit any);
    case (a)
      3'd0: return {24'b0, h2};
      3'd1: return {24'b0, m_dir};
      3'd2: return {24'b0, m_mask};
      3'd3: return {24'b0, any ? m_edge_any : m_edge};
      3'd6: return {31'b0, m_left > 0};
      default: return 32'b0;
    endcase
  endfunction

  // Advance one clock: apply the spec rules to the current bus/pin inputs.
  task automatic step();
    logic       wr;
    logic [7:0] wd, rise, fall;
    logic       n_irq, n_irq_any;
    wr   = chipselect && !write_n;
    wd   = writedata[7:0];
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    n_irq     = |(m_edge & m_mask);
    n_irq_any = |(m_edge_any & m_mask);
    if (wr && address == 3'd3) begin
      m_edge     = m_edge & ~wd;
      m_edge_any = m_edge_any & ~wd;
    end
    m_edge     = m_edge | rise;
    m_edge_any = m_edge_any | rise | fall;
    if (wr) begin
      case (address)
        3'd0: m_data = wd;
        3'd1: m_dir  = wd;
        3'd2: m_mask = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
    if (wr && address == 3'd6 && wd != 0) begin
      m_pmask = m_pmask | wd;
      m_left  = P;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_pmask = '0;
    end
    h3 = h2; h2 = h1; h1 = in_port;
    m_irq = n_irq; m_irq_any = n_irq_any;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d_r, output logic [31:0] d_a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d_r = readdata_r; d_a = readdata_a;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r, a;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (out_port_r !== RV) begin errors++; $display("FAIL reset_out_port: got %h expected %h", out_port_r, RV); end
    checks++; if (out_en_r !== 8'h00) begin errors++; $display("FAIL reset_out_en: got %h expected 00", out_en_r); end
    checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_r); end
    bus_read(3'd6, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", r); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    bus_read(3'd3, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_edge: got %h expected 0", r); end
    checks++; if (out_port_r !== RV) begin errors++; $display("FAIL post_reset_out_port: got %h expected %h", out_port_r, RV); end
  endtask

  task automatic test_data_ops();
    logic [31:0] r, a;
    bus_write(3'd0, 32'hA5);
    checks++; if (out_port_r !== 8'hA5) begin errors++; $display("FAIL data_write: got %h expected a5", out_port_r); end
    bus_write(3'd4, 32'h02);
    checks++; if (out_port_r !== 8'hA7) begin errors++; $display("FAIL outset: got %h expected a7", out_port_r); end
    bus_write(3'd5, 32'h80);
    checks++; if (out_port_r !== 8'h27) begin errors++; $display("FAIL outclr: got %h expected 27", out_port_r); end
    bus_read(3'd4, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL outset_read: got %h expected 0", r); end
    bus_read(3'd5, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL outclr_read: got %h expected 0", r); end
  endtask

  task automatic test_dir();
    logic [31:0] r, a;
    bus_write(3'd1, 32'hFF);
    bus_read(3'd1, r, a);
    checks++; if (r !== 32'hFF) begin errors++; $display("FAIL dir_read: got %h expected ff", r); end
    checks++; if (out_en_r !== 8'hFF) begin errors++; $display("FAIL dir_out_en: got %h expected ff", out_en_r); end
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL addr7_read: got %h expected 0", r); end
    bus_read(3'd2, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL addr7_no_effect_mask: got %h expected 0", r); end
    checks++; if (out_port_r !== 8'h27) begin errors++; $display("FAIL addr7_no_effect_data: got %h expected 27", out_port_r); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] r, a;
    bus_write(3'd2, 32'h01);
    in_port = 8'h01;
    step();
    bus_read(3'd3, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL edge_early1: got %h expected 0", r); end
    step();
    bus_read(3'd3, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL edge_early2: got %h expected 0", r); end
    bus_read(3'd0, r, a);
    checks++; if (r !== 32'h01) begin errors++; $display("FAIL in_sync_read: got %h expected 1", r); end
    step();
    bus_read(3'd3, r, a);
    checks++; if (r !== 32'h01) begin errors++; $display("FAIL edge_set: got %h expected 1", r); end
    checks++; if (a !== 32'h01) begin errors++; $display("FAIL edge_any_set: got %h expected 1", a); end
    checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq_r); end
    step();
    checks++; if (irq_r !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq_r); end
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL edge_w1c: got %h expected 0", r); end
    step();
    checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq_r); end
  endtask

  task automatic test_collision();
    logic [31:0] r, a;
    in_port = 8'h00;
    repeat (4) step();
    bus_write(3'd3, 32'hFF);
    in_port = 8'h01;
    step();
    step();
    bus_write(3'd3, 32'h01);   // lands on the same edge that captures the rise
    bus_read(3'd3, r, a);
    checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL collision_set_wins: got %b expected 1", r[0]); end
    checks++; if (r !== model_read(3'd3, 1'b0)) begin errors++; $display("FAIL collision_model: got %h expected %h", r, model_read(3'd3, 1'b0)); end
    bus_write(3'd3, 32'hFF);
    step();
  endtask

  task automatic test_pulse();
    logic [31:0] r, a;
    int hi;
    bus_write(3'd0, 32'h00);
    bus_write(3'd6, 32'h01);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      bus_read(3'd6, r, a);
      if (out_port_r[0] === 1'b1 && r === 32'd1) hi++;
      if (i == 3) bus_write(3'd0, 32'h80);
      else step();
    end
    checks++; if (hi != P) begin errors++; $display("FAIL pulse_len: got %0d expected %0d", hi, P); end
    bus_read(3'd6, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL pulse_busy_end: got %h expected 0", r); end
    checks++; if (out_port_r !== 8'h80) begin errors++; $display("FAIL pulse_end_data: got %h expected 80", out_port_r); end
    // restart after five cycles extends the pulse to fifteen
    bus_write(3'd0, 32'h00);
    bus_write(3'd6, 32'h01);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_port_r[0] === 1'b1) hi++;
      if (i < 4) step();
    end
    bus_write(3'd6, 32'h01);
    for (int i = 0; i < P; i++) begin
      if (out_port_r[0] === 1'b1) hi++;
      step();
    end
    checks++; if (hi != 15) begin errors++; $display("FAIL pulse_restart_len: got %0d expected 15", hi); end
    checks++; if (out_port_r[0] !== 1'b0) begin errors++; $display("FAIL pulse_restart_end: got %b expected 0", out_port_r[0]); end
  endtask

  task automatic test_pulse_zero();
    logic [31:0] r, a;
    bus_write(3'd6, 32'h100);
    bus_read(3'd6, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL pulse_zero_busy: got %h expected 0", r); end
    checks++; if (out_port_r !== 8'h00) begin errors++; $display("FAIL pulse_zero_out: got %h expected 00", out_port_r); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] r, a;
    int bad;
    bus_write(3'd6, 32'h0F);
    step(); step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_port_r !== RV) begin errors++; $display("FAIL midpulse_out_port: got %h expected %h", out_port_r, RV); end
    bus_read(3'd6, r, a);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL midpulse_busy: got %h expected 0", r); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < P + 2; i++) begin
      step();
      if (out_port_r !== RV) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midpulse_no_resume: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_random();
    logic [31:0] r, a, e;
    logic [2:0]  ra;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ 8'($urandom);
      if ($urandom_range(2) == 0) begin
        address = 3'($urandom); writedata = $urandom;
        chipselect = 1'b1; write_n = 1'b0;
      end
      step();
      chipselect = 1'b0; write_n = 1'b1;
      checks++; if (out_port_r !== (m_data | m_pmask)) begin errors++; $display("FAIL rnd_out_port c=%0d: got %h expected %h", c, out_port_r, m_data | m_pmask); end
      checks++; if (out_port_a !== (m_data | m_pmask)) begin errors++; $display("FAIL rnd_out_port_any c=%0d: got %h expected %h", c, out_port_a, m_data | m_pmask); end
      checks++; if (out_en_r !== m_dir) begin errors++; $display("FAIL rnd_out_en c=%0d: got %h expected %h", c, out_en_r, m_dir); end
      checks++; if (irq_r !== m_irq) begin errors++; $display("FAIL rnd_irq c=%0d: got %b expected %b", c, irq_r, m_irq); end
      checks++; if (irq_a !== m_irq_any) begin errors++; $display("FAIL rnd_irq_any c=%0d: got %b expected %b", c, irq_a, m_irq_any); end
      ra = 3'($urandom);
      bus_read(ra, r, a);
      e = model_read(ra, 1'b0);
      checks++; if (r !== e) begin errors++; $display("FAIL rnd_read a=%0d c=%0d: got %h expected %h", ra, c, r, e); end
      e = model_read(ra, 1'b1);
      checks++; if (a !== e) begin errors++; $display("FAIL rnd_read_any a=%0d c=%0d: got %h expected %h", ra, c, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_data_ops();
    test_dir();
    test_edge_irq();
    test_collision();
    test_pulse();
    test_pulse_zero();
    test_reset_mid_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
